control_unit: RTL

Multi-cycle sequencer for the K&S 16-bit processor. It consumes the decoded instruction and registered flags from `data_path` and drives every datapath control strobe: PC update, IR load, address mux, register-file write source, ALU operation, and flag and RAM write enables. It sits beside `data_path` inside the processor top. It is the only writer of `ram_write_enable` and `halt`.

---
 rtl/k_and_s_pkg.sv | 73 +++++++
 rtl/control_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types and constants for the K&S 16-bit processor.
//   decoded_instruction_type : instruction class produced by data_path.
//                              The 5-bit encoding leaves room for values that
//                              match no instruction; the sequencer treats those
//                              as no-ops.
//   ctrl_state_type          : control_unit sequencer states.
//   ctrl_out_type            : bundle of every control strobe driven by
//                              control_unit.
//   OP_*                     : ALU operation codes, shared with data_path.
package k_and_s_pkg;

   typedef enum logic [4:0] {
      I_NOP    = 5'd0,
      I_LOAD   = 5'd1,
      I_STORE  = 5'd2,
      I_MOVE   = 5'd3,
      I_ADD    = 5'd4,
      I_SUB    = 5'd5,
      I_AND    = 5'd6,
      I_OR     = 5'd7,
      I_BRANCH = 5'd8,
      I_BZERO  = 5'd9,
      I_BNZERO = 5'd10,
      I_BNEG   = 5'd11,
      I_BNNEG  = 5'd12,
      I_BOV    = 5'd13,
      I_BNOV   = 5'd14,
      I_HALT   = 5'd15
   } decoded_instruction_type;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      LOAD   = 4'd2,
      STORE  = 4'd3,
      MOVE   = 4'd4,
      ALU    = 4'd5,
      BRANCH = 4'd6,
      NOP    = 4'd7,
      HALT   = 4'd8
   } ctrl_state_type;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef struct packed {
      logic       branch;
      logic       pc_enable;
      logic       ir_enable;
      logic       addr_sel;
      logic       c_sel;
      logic [1:0] operation;
      logic       write_reg_enable;
      logic       flags_reg_enable;
      logic       ram_write_enable;
      logic       halt;
   } ctrl_out_type;

   // True for every conditional or unconditional branch instruction.
   function automatic logic is_branch_instr(input decoded_instruction_type instr);
      logic result;
      result = 1'b0;
      case (instr)
         I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
         I_BNNEG, I_BOV, I_BNOV: result = 1'b1;
         default:                result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore sequencer for the K&S 16-bit processor.
// Every instruction runs FETCH -> DECODE -> execute state -> FETCH, except
// HALT, which parks the machine until reset.
//
// Ports:
//   clk                  in   clock, rising edge
//   rst_n                in   asynchronous active-low reset
//   decoded_instruction  in   instruction class from data_path (IR decode)
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow      in   registered ALU flags from data_path
//   branch               out  PC loads the branch target instead of PC+1
//   pc_enable            out  PC update on this edge
//   ir_enable            out  IR loads data_in
//   addr_sel             out  ram_addr source: 0 = PC, 1 = instruction address
//   c_sel                out  register write source: 0 = ALU, 1 = data_in
//   operation[1:0]       out  ALU operation (OP_ADD/OP_AND/OP_OR/OP_SUB)
//   write_reg_enable     out  register-file write
//   flags_reg_enable     out  flag register update
//   ram_write_enable     out  RAM write of data_out at ram_addr
//   halt                 out  processor stopped
module control_unit
   import k_and_s_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halt
);

   ctrl_state_type state_q;
   ctrl_state_type state_d;
   ctrl_out_type   ctrl_raw;
   ctrl_out_type   ctrl;

   // No branch condition looks at the unsigned carry flag.
   logic unused_flags;
   assign unused_flags = unsigned_overflow;

   // Branch resolution from the flags present in the BRANCH cycle.
   function automatic logic branch_taken(input decoded_instruction_type instr,
                                         input logic z,
                                         input logic n,
                                         input logic sv);
      logic taken;
      taken = 1'b0;
      case (instr)
         I_BRANCH: taken = 1'b1;
         I_BZERO:  taken = z;
         I_BNZERO: taken = ~z;
         I_BNEG:   taken = n;
         I_BNNEG:  taken = ~n;
         I_BOV:    taken = sv;
         I_BNOV:   taken = ~sv;
         default:  taken = 1'b0;
      endcase
      return taken;
   endfunction

   // ALU operation code for the arithmetic/logic instruction classes.
   function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
      logic [1:0] op;
      op = OP_ADD;
      case (instr)
         I_ADD:   op = OP_ADD;
         I_AND:   op = OP_AND;
         I_OR:    op = OP_OR;
         I_SUB:   op = OP_SUB;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ctrl_raw = '0;
      case (state_q)
         FETCH: begin
            ctrl_raw.ir_enable = 1'b1;
            ctrl_raw.addr_sel  = 1'b0;
            state_d            = DECODE;
         end
         DECODE: begin
            case (decoded_instruction)
               I_LOAD:                     state_d = LOAD;
               I_STORE:                    state_d = STORE;
               I_MOVE:                     state_d = MOVE;
               I_ADD, I_SUB, I_AND, I_OR:  state_d = ALU;
               I_HALT:                     state_d = HALT;
               default: begin
                  if (is_branch_instr(decoded_instruction)) begin
                     state_d = BRANCH;
                  end else begin
                     state_d = NOP;
                  end
               end
            endcase
         end
         LOAD: begin
            ctrl_raw.addr_sel         = 1'b1;
            ctrl_raw.c_sel            = 1'b1;
            ctrl_raw.write_reg_enable = 1'b1;
            ctrl_raw.pc_enable        = 1'b1;
            state_d                   = FETCH;
         end
         STORE: begin
            ctrl_raw.addr_sel         = 1'b1;
            ctrl_raw.ram_write_enable = 1'b1;
            ctrl_raw.pc_enable        = 1'b1;
            state_d                   = FETCH;
         end
         MOVE: begin
            // data_path drives the source register onto both ALU inputs,
            // so OR passes it through unchanged; flags stay untouched.
            ctrl_raw.operation        = OP_OR;
            ctrl_raw.c_sel            = 1'b0;
            ctrl_raw.write_reg_enable = 1'b1;
            ctrl_raw.pc_enable        = 1'b1;
            state_d                   = FETCH;
         end
         ALU: begin
            ctrl_raw.operation        = alu_op(decoded_instruction);
            ctrl_raw.c_sel            = 1'b0;
            ctrl_raw.write_reg_enable = 1'b1;
            ctrl_raw.flags_reg_enable = 1'b1;
            ctrl_raw.pc_enable        = 1'b1;
            state_d                   = FETCH;
         end
         BRANCH: begin
            ctrl_raw.pc_enable = 1'b1;
            ctrl_raw.branch    = branch_taken(decoded_instruction, zero_op,
                                              neg_op, signed_overflow);
            state_d            = FETCH;
         end
         NOP: begin
            ctrl_raw.pc_enable = 1'b1;
            state_d            = FETCH;
         end
         HALT: begin
            ctrl_raw.halt = 1'b1;
            state_d       = HALT;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // Reset masks every strobe immediately, so a write in flight when rst_n
   // falls is killed in that same cycle rather than at the next edge. It
   // also keeps the FETCH strobes quiet while reset is held.
   assign ctrl = rst_n ? ctrl_raw : '0;

   assign branch           = ctrl.branch;
   assign pc_enable        = ctrl.pc_enable;
   assign ir_enable        = ctrl.ir_enable;
   assign addr_sel         = ctrl.addr_sel;
   assign c_sel            = ctrl.c_sel;
   assign operation        = ctrl.operation;
   assign write_reg_enable = ctrl.write_reg_enable;
   assign flags_reg_enable = ctrl.flags_reg_enable;
   assign ram_write_enable = ctrl.ram_write_enable;
   assign halt             = ctrl.halt;

endmodule
